// File: rtl/pc_pkg.sv
// pc_pkg: shared op encoding and control-priority encoder for the program counter
package pc_pkg;
  typedef enum logic [2:0] {
    OP_NONE,
    OP_INC,
    OP_BR,
    OP_LD,
    OP_CALL,
    OP_RET,
    OP_CLR
  } op_e;
  function automatic op_e pc_op(
    input logic clr,
    input logic ret,
    input logic call,
    input logic ld,
    input logic br,
    input logic ipc
  );
    return clr ? OP_CLR : ret ? OP_RET : call ? OP_CALL : ld ? OP_LD : br ? OP_BR : ipc ? OP_INC : OP_NONE;
  endfunction
endpackage

// File: rtl/pc_stack.sv
// pc_stack: DEPTH-entry LIFO of return addresses; reports over/underflow instead of acting on it
module pc_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int SPW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [SPW-1:0]   sp,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             unf
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [SPW-1:0]   sp_q, sp_d;
  assign full  = sp_q == SPW'(DEPTH);
  assign empty = sp_q == '0;
  assign ovf   = push & full;
  assign unf   = pop & empty;
  assign sp    = sp_q;
  always_comb sp_d = push && !full ? sp_q + SPW'(1) : pop && !empty ? sp_q - SPW'(1) : sp_q;
  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) top = sp_q == SPW'(i + 1) ? mem_q[i] : top;
  end
  always_ff @(posedge clk)
    if (rst) sp_q <= '0;
    else sp_q <= sp_d;
  // Entries are not reset: contents are only ever read below the occupancy pointer
  always_ff @(posedge clk)
    for (int i = 0; i < DEPTH; i++)
      if (push && !full && sp_q == SPW'(i)) mem_q[i] <= din;
endmodule

// File: rtl/pc_seq.sv
// pc_seq: program counter with increment, absolute jump, relative branch and call/return stack
module pc_seq
  import pc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  localparam int SPW = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             IPC,
  input  logic             LD,
  input  logic             BR,
  input  logic [7:0]       OFS,
  input  logic             CALL,
  input  logic             RET,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic [SPW-1:0]   SP,
  output logic             FULL,
  output logic             EMPTY,
  output logic             ERR
);
  op_e              op;
  logic [WIDTH-1:0] q_q, q_d, ofs_x, top;
  logic             err_q, ovf, unf;
  assign op = pc_op(CLR, RET, CALL, LD, BR, IPC);
  // Narrow counters drop the high offset bits; wide ones sign-extend from bit 7
  if (WIDTH < 8) begin : g_trunc
    logic unused_ofs;
    assign ofs_x      = OFS[WIDTH-1:0];
    assign unused_ofs = ^OFS[7:WIDTH];
  end else begin : g_sext
    assign ofs_x = WIDTH'($signed(OFS));
  end
  pc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
    .clk  (CLK),
    .rst  (CLR),
    .push (op == OP_CALL),
    .pop  (op == OP_RET),
    .din  (q_q + WIDTH'(1)),
    .top  (top),
    .sp   (SP),
    .full (FULL),
    .empty(EMPTY),
    .ovf  (ovf),
    .unf  (unf)
  );
  always_comb
    q_d = op == OP_RET ? (EMPTY ? q_q : top) :
          op == OP_CALL || op == OP_LD ? D :
          op == OP_BR ? q_q + ofs_x :
          op == OP_INC ? q_q + WIDTH'(1) : q_q;
  always_ff @(posedge CLK)
    if (CLR) begin
      q_q   <= RESET_VEC;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      err_q <= err_q | ovf | unf;
    end
  assign Q   = q_q;
  assign ERR = err_q;
  assign RCO = IPC & (&q_q);
endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: directed vectors for pc_seq in three parameterisations driven from shared controls
module tb_pc_seq;
  localparam logic [5:0] C_CLR = 6'b100000, C_RET = 6'b010000, C_CALL = 6'b001000;
  localparam logic [5:0] C_LD = 6'b000100, C_BR = 6'b000010, C_IPC = 6'b000001;
  typedef struct {
    logic [5:0] c;
    logic [7:0] o;
    logic [7:0] d;
    logic [7:0] q;
    int         sp;
    logic       err;
    logic       rco;
  } vec_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic clr, ret, call, ld, br, ipc;
  logic [7:0]  ofs;
  logic [15:0] d;
  logic [7:0]  q8;
  logic [2:0]  sp8;
  logic        rco8, full8, empty8, err8;
  logic [3:0]  q4;
  logic [0:0]  sp4;
  logic        rco4, full4, empty4, err4;
  logic [15:0] q16;
  logic [3:0]  sp16;
  logic        rco16, full16, empty16, err16;
  logic        rco8_s, rco4_s, rco16_s;
  int n_cmp = 0, n_bad = 0;
  vec_t tv[$];
  pc_seq #(.WIDTH(8), .DEPTH(4), .RESET_VEC(8'hF0)) u8 (
    .CLK(clk), .CLR(clr), .IPC(ipc), .LD(ld), .BR(br), .OFS(ofs), .CALL(call), .RET(ret),
    .D(d[7:0]), .Q(q8), .RCO(rco8), .SP(sp8), .FULL(full8), .EMPTY(empty8), .ERR(err8));
  pc_seq #(.WIDTH(4), .DEPTH(1), .RESET_VEC(4'h0)) u4 (
    .CLK(clk), .CLR(clr), .IPC(ipc), .LD(ld), .BR(br), .OFS(ofs), .CALL(call), .RET(ret),
    .D(d[3:0]), .Q(q4), .RCO(rco4), .SP(sp4), .FULL(full4), .EMPTY(empty4), .ERR(err4));
  pc_seq #(.WIDTH(16), .DEPTH(8), .RESET_VEC(16'h0010)) u16 (
    .CLK(clk), .CLR(clr), .IPC(ipc), .LD(ld), .BR(br), .OFS(ofs), .CALL(call), .RET(ret),
    .D(d), .Q(q16), .RCO(rco16), .SP(sp16), .FULL(full16), .EMPTY(empty16), .ERR(err16));
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic go(input logic [5:0] c, input logic [7:0] o, input logic [15:0] dd);
    {clr, ret, call, ld, br, ipc} = c;
    ofs = o;
    d   = dd;
    #1;
    rco8_s  = rco8;
    rco4_s  = rco4;
    rco16_s = rco16;
    @(posedge clk);
    #1;
  endtask
  task automatic st(input string nm, input int inst, input logic [15:0] q, input int sp, input logic err);
    logic [15:0] qa;
    int spa, dep;
    logic ea, fa, ema;
    qa  = inst == 0 ? 16'(q8) : inst == 1 ? 16'(q4) : q16;
    spa = inst == 0 ? int'(sp8) : inst == 1 ? int'(sp4) : int'(sp16);
    dep = inst == 0 ? 4 : inst == 1 ? 1 : 8;
    ea  = inst == 0 ? err8 : inst == 1 ? err4 : err16;
    fa  = inst == 0 ? full8 : inst == 1 ? full4 : full16;
    ema = inst == 0 ? empty8 : inst == 1 ? empty4 : empty16;
    chk({nm, " q"}, qa, q);
    chk({nm, " sp"}, 16'(spa), 16'(sp));
    chk({nm, " err"}, 16'(ea), 16'(err));
    chk({nm, " full"}, 16'(fa), 16'(sp == dep));
    chk({nm, " empty"}, 16'(ema), 16'(sp == 0));
  endtask
  task automatic add(input logic [5:0] c, input logic [7:0] o, input logic [7:0] dd, input logic [7:0] q,
                     input int sp, input logic err, input logic rco);
    vec_t v;
    v.c = c; v.o = o; v.d = dd; v.q = q; v.sp = sp; v.err = err; v.rco = rco;
    tv.push_back(v);
  endtask
  initial begin
    {clr, ret, call, ld, br, ipc} = '0;
    ofs = '0;
    d   = '0;
    add(C_CLR, 0, 0, 8'hF0, 0, 0, 0);
    for (int i = 0; i < 16; i++) add(C_IPC, 0, 0, 8'(8'hF0 + i + 1), 0, 0, i == 15);
    add(C_LD, 0, 8'h40, 8'h40, 0, 0, 0);
    add(C_BR, 8'hFE, 0, 8'h3E, 0, 0, 0);
    add(C_BR, 8'h05, 0, 8'h43, 0, 0, 0);
    add(C_LD | C_IPC, 0, 8'h10, 8'h10, 0, 0, 0);
    add(6'b0, 8'h33, 8'h77, 8'h10, 0, 0, 0);
    add(C_LD, 0, 8'hFF, 8'hFF, 0, 0, 0);
    add(C_LD | C_IPC, 0, 8'h12, 8'h12, 0, 0, 1);
    add(C_LD, 0, 8'h20, 8'h20, 0, 0, 0);
    add(C_CALL, 0, 8'h80, 8'h80, 1, 0, 0);
    add(C_CALL, 0, 8'h90, 8'h90, 2, 0, 0);
    add(C_RET, 0, 0, 8'h81, 1, 0, 0);
    add(C_RET, 0, 0, 8'h21, 0, 0, 0);
    for (int i = 1; i <= 4; i++) add(C_CALL, 0, 8'(i), 8'(i), i, 0, 0);
    add(C_CALL, 0, 8'h05, 8'h05, 4, 1, 0);
    add(C_RET, 0, 0, 8'h04, 3, 1, 0);
    add(C_RET, 0, 0, 8'h03, 2, 1, 0);
    add(C_RET, 0, 0, 8'h02, 1, 1, 0);
    add(C_RET, 0, 0, 8'h22, 0, 1, 0);
    add(C_CLR, 0, 0, 8'hF0, 0, 0, 0);
    add(C_RET, 0, 0, 8'hF0, 0, 1, 0);
    add(C_IPC, 0, 0, 8'hF1, 0, 1, 0);
    add(C_LD, 0, 8'h33, 8'h33, 0, 1, 0);
    add(C_CLR, 0, 0, 8'hF0, 0, 0, 0);
    add(C_CLR | C_CALL, 0, 8'h55, 8'hF0, 0, 0, 0);
    add(C_CALL, 0, 8'h50, 8'h50, 1, 0, 0);
    add(C_CALL | C_RET, 0, 8'h60, 8'hF1, 0, 0, 0);
    add(C_CALL | C_RET, 0, 8'h60, 8'hF1, 0, 1, 0);
    for (int i = 0; i < tv.size(); i++) begin
      go(tv[i].c, tv[i].o, {8'h00, tv[i].d});
      chk($sformatf("w8 v%0d rco", i), 16'(rco8_s), 16'(tv[i].rco));
      st($sformatf("w8 v%0d", i), 0, 16'(tv[i].q), tv[i].sp, tv[i].err);
    end
    go(C_CLR, 0, 0);                    st("w4 clr", 1, 16'h0, 0, 0);
    go(C_LD, 0, 16'hE);                 st("w4 ld", 1, 16'hE, 0, 0);
    go(C_BR, 8'h13, 0);                 st("w4 br13", 1, 16'h1, 0, 0);
    go(C_BR, 8'h80, 0);                 st("w4 br80", 1, 16'h1, 0, 0);
    go(C_LD, 0, 16'hF);
    go(C_IPC, 0, 0);
    chk("w4 rco", 16'(rco4_s), 16'h1);  st("w4 wrap", 1, 16'h0, 0, 0);
    go(C_CALL, 0, 16'h5);               st("w4 call", 1, 16'h5, 1, 0);
    go(C_CALL, 0, 16'h7);               st("w4 ovf", 1, 16'h7, 1, 1);
    go(C_RET, 0, 0);                    st("w4 ret", 1, 16'h1, 0, 1);
    go(C_CLR | C_CALL, 0, 16'h9);       st("w4 clrcall", 1, 16'h0, 0, 0);
    go(C_CALL, 0, 16'h5);               st("w4 call2", 1, 16'h5, 1, 0);
    go(C_RET | C_CALL, 0, 16'h9);       st("w4 retcall", 1, 16'h1, 0, 0);
    go(C_CLR, 0, 0);                    st("w16 clr", 2, 16'h0010, 0, 0);
    go(C_BR, 8'h80, 0);                 st("w16 br80", 2, 16'hFF90, 0, 0);
    go(C_BR, 8'h7F, 0);                 st("w16 br7f", 2, 16'h000F, 0, 0);
    go(C_IPC, 0, 0);                    st("w16 inc", 2, 16'h0010, 0, 0);
    go(C_LD, 0, 16'hFFFF);
    go(C_IPC, 0, 0);
    chk("w16 rco", 16'(rco16_s), 16'h1); st("w16 wrap", 2, 16'h0000, 0, 0);
    for (int i = 0; i < 8; i++) begin
      go(C_CALL, 0, 16'(16'h1000 + i));
      st($sformatf("w16 call%0d", i), 2, 16'(16'h1000 + i), i + 1, 0);
    end
    go(C_CALL, 0, 16'h2000);            st("w16 ovf", 2, 16'h2000, 8, 1);
    for (int i = 0; i < 7; i++) begin
      go(C_RET, 0, 0);
      st($sformatf("w16 ret%0d", i), 2, 16'(16'h1007 - i), 7 - i, 1);
    end
    go(C_RET, 0, 0);                    st("w16 ret7", 2, 16'h0001, 0, 1);
    go(C_CLR | C_CALL, 0, 16'h3000);    st("w16 clrcall", 2, 16'h0010, 0, 0);
    go(C_CALL, 0, 16'h3000);            st("w16 call", 2, 16'h3000, 1, 0);
    go(C_RET | C_CALL, 0, 16'h4000);    st("w16 retcall", 2, 16'h0011, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pc_seq.md
# pc_seq

Parametrised program counter with relative branch and a hardware call/return stack. It is the successor to the 8-bit LS161-pair counter and sits in the control path: it feeds the instruction-memory address and takes its jump, branch, call and return controls from the instruction decoder. Width, stack depth and reset vector are all configurable.

## Interface
Parameters:
- WIDTH, 8, counter/address width in bits (≥4)
- DEPTH, 4, return-stack entries (≥1)
- RESET_VEC, 0, value loaded into Q on CLR

Ports:
- CLK  input  1  rising-edge clock
- CLR  input  1  synchronous active-high reset
- IPC  input  1  increment enable
- LD  input  1  absolute jump: Q ← D
- BR  input  1  relative branch: Q ← Q + sign-extended OFS
- OFS  input  8  signed two's-complement branch offset
- CALL  input  1  push Q+1, then Q ← D
- RET  input  1  Q ← top of stack, then pop
- D  input  WIDTH  jump/call target
- Q  output  WIDTH  current program counter
- RCO  output  1  ripple carry: IPC & (Q == all ones), combinational
- SP  output  $clog2(DEPTH+1)  stack occupancy, 0..DEPTH
- FULL  output  1  SP == DEPTH
- EMPTY  output  1  SP == 0
- ERR  output  1  sticky stack overflow/underflow flag

## Operation
- One clock, CLK. Reset is synchronous and active-high on CLR.
- Priority per cycle: CLR > RET > CALL > LD > BR > IPC. Only the highest active control acts; the rest are ignored that cycle.
- CLR: Q ← RESET_VEC, SP ← 0, ERR ← 0. Stack contents are don't-care after CLR.
- RET, stack not empty: Q ← stack[SP-1], SP ← SP-1.
- RET, stack empty: Q holds, SP stays 0, ERR ← 1.
- CALL, stack not full: stack[SP] ← Q+1 (mod 2^WIDTH), SP ← SP+1, Q ← D.
- CALL, stack full: Q ← D, no push, SP holds, ERR ← 1.
- LD: Q ← D.
- BR: Q ← (Q + sext(OFS)) mod 2^WIDTH.
  - If WIDTH < 8, OFS is truncated to WIDTH bits before the add.
  - If WIDTH > 8, OFS is sign-extended from bit 7.
- IPC: Q ← Q+1 mod 2^WIDTH. All-ones wraps to 0, and RCO is high in the wrapping cycle.
- No control active: everything holds.
- ERR is sticky and is cleared only by CLR.
- FULL, EMPTY and SP are derived combinationally from the SP register.

## Timing
- All state updates on the rising CLK edge; zero-cycle internal latency. The new Q is visible in the cycle after the control is sampled.
- RCO is combinational from IPC and Q, with no register stage, so units can be cascaded.
- Reset values: Q = RESET_VEC, SP = 0, EMPTY = 1, FULL = 0, ERR = 0. RCO is 0 unless IPC is high and RESET_VEC is all ones.
- CLR asserted during any operation wins that edge; nothing is pushed and nothing is popped.
- Back-to-back CALL then RET returns to the pushed Q+1 on the second edge.
- CALL and RET in the same cycle: only RET acts. The CALL is lost and ERR is not set by the CALL.
- Controls are level-sampled each edge. Holding IPC high increments once per cycle.

## Structure
- Shared package pc_pkg holds:
  - the op encoding enum (OP_NONE, OP_INC, OP_BR, OP_LD, OP_CALL, OP_RET, OP_CLR)
  - a priority-encode function from the control inputs to that enum
- Sub-module pc_stack: a LIFO of DEPTH × WIDTH registers.
  - Inputs: push, pop, din.
  - Outputs: top, SP, full, empty.
  - It reports over/underflow, and the top level sets ERR from those reports.
- Top-level pc_seq holds the Q register, the adder/incrementer mux and the ERR flag.

## Test plan
- Reset/increment/wrap (WIDTH=8, RESET_VEC=8'hF0): CLR, then IPC for 16 cycles -> Q steps F0..FF then 00. RCO is high only while Q=FF.
- Jump and branch: LD with D=8'h40 -> Q=40. BR with OFS=8'hFE -> Q=3E. BR with OFS=8'h05 -> Q=43. LD and IPC together with D=10 -> Q=10, no increment.
- Call/return nesting (DEPTH=4): from Q=20, CALL D=80, then CALL D=90 -> Q=90, SP=2. RET -> Q=81. RET -> Q=21, EMPTY=1.
- Overflow: 5 CALLs with DEPTH=4 -> the 5th jumps, FULL stays 1, ERR=1. 4 RETs then unwind correctly to the first four return addresses.
- Underflow and sticky ERR: RET on an empty stack -> Q holds, ERR=1. Later IPC/LD leave ERR at 1. CLR -> ERR=0, Q=RESET_VEC.
- Parametric/priority sweep (WIDTH=4, DEPTH=1 and WIDTH=16, DEPTH=8):
  - CLR with CALL -> reset wins, SP=0.
  - RET with CALL on a non-empty stack -> pop only.
  - BR OFS=8'h80 at Q=16'h0010 -> Q=16'hFF90.
